mem_bridge: RTL

- Arbitrates the core's instruction-fetch port and data port onto one shared, variable-latency memory port.
- Exists so the next-generation core can use a unified memory instead of separate single-cycle instruction and data memories.
- Returns per-port ready pulses the core uses as stall release.
- Adds data-over-fetch priority with starvation protection, byte-lane writes and a bus timeout.

---
 rtl/mem_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: shares one variable-latency memory port between the fetch and data
// ports, with data-first arbitration, a fetch starvation limit and a bus timeout.
module mem_bridge #(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          MAX_DSTREAK = 4,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_err
);
    localparam logic [DW-1:0] ERR_WORD   = DW'(ERR_DATA);
    localparam logic [3:0]    STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [15:0]   TMO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

    state_t          state, state_next;
    logic [3:0]      streak, streak_next;
    logic [15:0]     tmo_cnt, tmo_cnt_next;
    logic            busy, grant_d, grant_f, ack_done, tmo_done;

    logic            mem_req_d, mem_we_d, if_ready_d, d_ready_d, bus_err_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d, if_rdata_d, d_rdata_d;
    logic [DW/8-1:0] mem_be_d;

    // Data wins unless a waiting fetch has already seen MAX_DSTREAK data grants in a row.
    always_comb begin
        busy     = (state == DATA) || (state == FETCH);
        grant_d  = (state == IDLE) && d_req && (!if_req || (streak < STREAK_MAX));
        grant_f  = (state == IDLE) && if_req && !grant_d;
        ack_done = busy && mem_ack;
        tmo_done = busy && !mem_ack && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (grant_d)              state_next = DATA;
                         else if (grant_f)         state_next = FETCH;
            DATA, FETCH: if (ack_done || tmo_done) state_next = RESP;
            RESP:                                  state_next = IDLE;
            default:                               state_next = IDLE;
        endcase

        streak_next = streak;
        if (state == IDLE) begin
            if (!if_req || grant_f) streak_next = '0;
            else if (grant_d)       streak_next = (streak == 4'hF) ? streak : streak + 4'd1;
        end
        tmo_cnt_next = (busy && !ack_done && !tmo_done) ? tmo_cnt + 16'd1 : '0;
    end

    // Next values of the registered outputs; an ack beats a timeout in the same cycle.
    always_comb begin
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;

        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_we ? d_be : '1;
        end else if (grant_f) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
        end

        if (ack_done || tmo_done) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            bus_err_d = tmo_done;
            if (state == DATA) begin
                d_rdata_d = ack_done ? mem_rdata : ERR_WORD;
                d_ready_d = 1'b1;
            end else begin
                if_rdata_d = ack_done ? mem_rdata : ERR_WORD;
                if_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak    <= '0;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            streak    <= streak_next;
            tmo_cnt   <= tmo_cnt_next;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            bus_err   <= bus_err_d;
        end
    end
endmodule
